// File: rtl/register_array_pkg.sv
// rtl/register_array_pkg.sv - shared types and helpers for the key/payload register-array priority queue
//
// Purpose: operation encoding and the elaboration-time size check used by
// register_array_kv. Entry structs live in the modules that use them because
// their width depends on module parameters.
package register_array_pkg;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ENQ,
    OP_DEQ,
    OP_REPLACE,
    OP_FLUSH
  } op_e;

  // The two compare-exchange layers pair slots, so the depth must be even.
  function automatic bit is_legal_size(input int n);
    return (n >= 4) && ((n % 2) == 0);
  endfunction

endpackage

// File: rtl/register_array_cas.sv
// rtl/register_array_cas.sv - compare-and-swap cell for {valid, key, data} entries
//
// Purpose: orders two entries by priority. A valid entry beats an invalid
// one; between valid entries the larger key wins (smaller when MIN_FIRST=1).
// Equal keys never swap, so the lower-index entry (i_a) keeps the hi output.
// Ports:
//   i_a, i_b  packed entries {valid, key, data}; i_a is the lower slot index
//   o_hi      higher-priority entry
//   o_lo      lower-priority entry
module register_array_cas #(
  parameter int KEY_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MIN_FIRST  = 0
) (
  input  logic [KEY_WIDTH+DATA_WIDTH:0] i_a,
  input  logic [KEY_WIDTH+DATA_WIDTH:0] i_b,
  output logic [KEY_WIDTH+DATA_WIDTH:0] o_hi,
  output logic [KEY_WIDTH+DATA_WIDTH:0] o_lo
);

  typedef struct packed {
    logic                  valid;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t a, b;
  logic   b_wins;

  assign a = entry_t'(i_a);
  assign b = entry_t'(i_b);

  always_comb begin
    b_wins = 1'b0;
    if (b.valid) begin
      if (!a.valid) begin
        b_wins = 1'b1;
      end else if (MIN_FIRST != 0) begin
        b_wins = (b.key < a.key);
      end else begin
        b_wins = (b.key > a.key);
      end
    end
  end

  assign o_hi = b_wins ? i_b : i_a;
  assign o_lo = b_wins ? i_a : i_b;

endmodule

// File: rtl/register_array_kv.sv
// rtl/register_array_kv.sv - register-array priority queue with key, payload and per-slot valid
//
// Purpose: holds up to QUEUE_SIZE {key, payload} entries and keeps the
// best-priority entry in slot 0 after every clock edge. Each cycle the
// post-operation array passes through one even-pair and one odd-pair
// compare-exchange layer before being registered.
// Ports:
//   i_CLK, i_RSTn            clock, asynchronous active-low reset
//   i_flush                  synchronous clear of all slots (wins over enq/deq)
//   i_enq_valid/o_enq_ready  enqueue handshake; i_enq_key/i_enq_data entry
//   i_deq                    pop the head (ignored when empty)
//   o_head_valid/key/data    registered slot 0
//   o_count, o_full, o_empty occupancy
module register_array_kv
  import register_array_pkg::*;
#(
  parameter int QUEUE_SIZE = 8,
  parameter int KEY_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MIN_FIRST  = 0
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic                          i_flush,
  input  logic                          i_enq_valid,
  output logic                          o_enq_ready,
  input  logic [KEY_WIDTH-1:0]          i_enq_key,
  input  logic [DATA_WIDTH-1:0]         i_enq_data,
  input  logic                          i_deq,
  output logic                          o_head_valid,
  output logic [KEY_WIDTH-1:0]          o_head_key,
  output logic [DATA_WIDTH-1:0]         o_head_data,
  output logic [$clog2(QUEUE_SIZE):0]   o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int CW = $clog2(QUEUE_SIZE) + 1;

  if (!is_legal_size(QUEUE_SIZE)) begin : g_size_check
    $error("register_array_kv: QUEUE_SIZE must be even and >= 4");
  end

  typedef struct packed {
    logic                  valid;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        slots_q [QUEUE_SIZE];
  entry_t        slots_d [QUEUE_SIZE];
  entry_t        stage1  [QUEUE_SIZE];
  entry_t        layer_a [QUEUE_SIZE];
  logic [CW-1:0] count_q, count_d;

  op_e  op;
  logic enq_acc, deq_acc;
  int   free_idx;

  assign o_full       = (count_q == CW'(QUEUE_SIZE));
  assign o_empty      = (count_q == '0);
  assign o_count      = count_q;
  // A replace never grows the queue, so a full queue can still accept it.
  assign o_enq_ready  = !o_full || i_deq;
  assign o_head_valid = slots_q[0].valid;
  assign o_head_key   = slots_q[0].key;
  assign o_head_data  = slots_q[0].data;

  assign enq_acc = i_enq_valid && o_enq_ready;
  assign deq_acc = i_deq && !o_empty;

  always_comb begin
    op = OP_NOP;
    if (i_flush)                op = OP_FLUSH;
    else if (enq_acc && deq_acc) op = OP_REPLACE;
    else if (enq_acc)           op = OP_ENQ;
    else if (deq_acc)           op = OP_DEQ;
  end

  // Lowest-index empty slot; an accepted plain enqueue implies one exists.
  always_comb begin
    free_idx = QUEUE_SIZE - 1;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) free_idx = i;
    end
  end

  always_comb begin
    stage1  = slots_q;
    count_d = count_q;
    case (op)
      OP_FLUSH: begin
        for (int i = 0; i < QUEUE_SIZE; i++) stage1[i] = '0;
        count_d = '0;
      end
      OP_REPLACE: begin
        stage1[0] = '{valid: 1'b1, key: i_enq_key, data: i_enq_data};
      end
      OP_ENQ: begin
        // Shift only up to the first hole so entries beyond it stay put.
        for (int i = 1; i < QUEUE_SIZE; i++) begin
          if (i <= free_idx) stage1[i] = slots_q[i-1];
        end
        stage1[0] = '{valid: 1'b1, key: i_enq_key, data: i_enq_data};
        count_d   = count_q + CW'(1);
      end
      OP_DEQ: begin
        stage1[0] = '0;
        count_d   = count_q - CW'(1);
      end
      default: ;
    endcase
  end

  for (genvar p = 0; p < QUEUE_SIZE / 2; p++) begin : g_layer_a
    register_array_cas #(
      .KEY_WIDTH (KEY_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .MIN_FIRST (MIN_FIRST)
    ) u_cas (
      .i_a (stage1[2*p]),
      .i_b (stage1[2*p+1]),
      .o_hi(layer_a[2*p]),
      .o_lo(layer_a[2*p+1])
    );
  end

  for (genvar p = 0; p < QUEUE_SIZE / 2 - 1; p++) begin : g_layer_b
    register_array_cas #(
      .KEY_WIDTH (KEY_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .MIN_FIRST (MIN_FIRST)
    ) u_cas (
      .i_a (layer_a[2*p+1]),
      .i_b (layer_a[2*p+2]),
      .o_hi(slots_d[2*p+1]),
      .o_lo(slots_d[2*p+2])
    );
  end

  assign slots_d[0]            = layer_a[0];
  assign slots_d[QUEUE_SIZE-1] = layer_a[QUEUE_SIZE-1];

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < QUEUE_SIZE; i++) slots_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) slots_q[i] <= slots_d[i];
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_register_array_kv.sv
// tb/tb_register_array_kv.sv - scoreboard bench for register_array_kv, max-first and min-first instances
module tb_register_array_kv;

  localparam int N  = 8;
  localparam int KW = 16;
  localparam int DW = 16;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, enq_valid, deq;
  logic [KW-1:0] enq_key;
  logic [DW-1:0] enq_data;

  logic          mx_enq_ready, mx_head_valid, mx_full, mx_empty;
  logic [KW-1:0] mx_head_key;
  logic [DW-1:0] mx_head_data;
  logic [CW-1:0] mx_count;
  logic          mn_enq_ready, mn_head_valid, mn_full, mn_empty;
  logic [KW-1:0] mn_head_key;
  logic [DW-1:0] mn_head_data;
  logic [CW-1:0] mn_count;

  always #5 clk = ~clk;

  register_array_kv #(.QUEUE_SIZE(N), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .MIN_FIRST(0)) u_max (
    .i_CLK(clk), .i_RSTn(rst_n), .i_flush(flush), .i_enq_valid(enq_valid),
    .o_enq_ready(mx_enq_ready), .i_enq_key(enq_key), .i_enq_data(enq_data), .i_deq(deq),
    .o_head_valid(mx_head_valid), .o_head_key(mx_head_key), .o_head_data(mx_head_data),
    .o_count(mx_count), .o_full(mx_full), .o_empty(mx_empty)
  );

  register_array_kv #(.QUEUE_SIZE(N), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .MIN_FIRST(1)) u_min (
    .i_CLK(clk), .i_RSTn(rst_n), .i_flush(flush), .i_enq_valid(enq_valid),
    .o_enq_ready(mn_enq_ready), .i_enq_key(enq_key), .i_enq_data(enq_data), .i_deq(deq),
    .o_head_valid(mn_head_valid), .o_head_key(mn_head_key), .o_head_data(mn_head_data),
    .o_count(mn_count), .o_full(mn_full), .o_empty(mn_empty)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bag model per ordering: 0 = max-first, 1 = min-first.
  int mk   [2][N];
  int md   [2][N];
  bit mv   [2][N];
  int mcnt [2];

  typedef struct {
    int cyc;
    bit hv0; int k0; int d0; bit dc0;
    bit hv1; int k1; int d1; bit dc1;
    int cnt;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int best_idx(input int o);
    int b = -1;
    for (int i = 0; i < N; i++) begin
      if (mv[o][i] && (b < 0 || (o == 0 ? mk[o][i] > mk[o][b] : mk[o][i] < mk[o][b]))) b = i;
    end
    return b;
  endfunction

  function automatic bit key_unique(input int o, input int b);
    int n = 0;
    for (int i = 0; i < N; i++) if (mv[o][i] && mk[o][i] == mk[o][b]) n++;
    return (n == 1);
  endfunction

  task automatic model_clear();
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < N; i++) begin
        mv[o][i] = 1'b0; mk[o][i] = 0; md[o][i] = 0;
      end
      mcnt[o] = 0;
    end
  endtask

  task automatic model_op(input bit f, input bit ev, input int k, input int d, input bit dq);
    for (int o = 0; o < 2; o++) begin
      bit enq_acc, deq_acc;
      enq_acc = ev && (mcnt[o] < N || dq);
      deq_acc = dq && (mcnt[o] > 0);
      if (f) begin
        for (int i = 0; i < N; i++) mv[o][i] = 1'b0;
        mcnt[o] = 0;
      end else begin
        if (deq_acc) begin
          mv[o][best_idx(o)] = 1'b0;
          mcnt[o]--;
        end
        if (enq_acc) begin
          for (int i = 0; i < N; i++) begin
            if (!mv[o][i]) begin
              mv[o][i] = 1'b1; mk[o][i] = k; md[o][i] = d;
              break;
            end
          end
          mcnt[o]++;
        end
      end
    end
  endtask

  // Drive one operation for exactly one clock and queue the head expected after it.
  task automatic step(input bit f, input bit ev, input int k, input int d, input bit dq);
    exp_t e;
    int   b;
    @(posedge clk); #1;
    flush = f; enq_valid = ev; enq_key = KW'(k); enq_data = DW'(d); deq = dq;
    model_op(f, ev, k, d, dq);
    e.cyc = cyc + 1;
    b = best_idx(0);
    e.hv0 = (b >= 0); e.k0 = (b >= 0) ? mk[0][b] : 0; e.d0 = (b >= 0) ? md[0][b] : 0;
    e.dc0 = (b >= 0) ? key_unique(0, b) : 1'b1;
    b = best_idx(1);
    e.hv1 = (b >= 0); e.k1 = (b >= 0) ? mk[1][b] : 0; e.d1 = (b >= 0) ? md[1][b] : 0;
    e.dc1 = (b >= 0) ? key_unique(1, b) : 1'b1;
    e.cnt = mcnt[0];
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("max head_valid", 32'(mx_head_valid), 32'(e.hv0));
      chk("max head_key",   32'(mx_head_key),   e.k0);
      if (e.dc0) chk("max head_data", 32'(mx_head_data), e.d0);
      chk("max count",      32'(mx_count),      e.cnt);
      chk("max full",       32'(mx_full),       32'(e.cnt == N));
      chk("max empty",      32'(mx_empty),      32'(e.cnt == 0));
      chk("min head_valid", 32'(mn_head_valid), 32'(e.hv1));
      chk("min head_key",   32'(mn_head_key),   e.k1);
      if (e.dc1) chk("min head_data", 32'(mn_head_data), e.d1);
      chk("min count",      32'(mn_count),      e.cnt);
      chk("min full",       32'(mn_full),       32'(e.cnt == N));
      chk("min empty",      32'(mn_empty),      32'(e.cnt == 0));
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " max head_valid"}, 32'(mx_head_valid), 0);
    chk({tag, " max head_key"},   32'(mx_head_key),   0);
    chk({tag, " max head_data"},  32'(mx_head_data),  0);
    chk({tag, " max count"},      32'(mx_count),      0);
    chk({tag, " max full"},       32'(mx_full),       0);
    chk({tag, " max empty"},      32'(mx_empty),      1);
    chk({tag, " max enq_ready"},  32'(mx_enq_ready),  1);
    chk({tag, " min head_valid"}, 32'(mn_head_valid), 0);
    chk({tag, " min head_key"},   32'(mn_head_key),   0);
    chk({tag, " min head_data"},  32'(mn_head_data),  0);
    chk({tag, " min count"},      32'(mn_count),      0);
    chk({tag, " min full"},       32'(mn_full),       0);
    chk({tag, " min empty"},      32'(mn_empty),      1);
    chk({tag, " min enq_ready"},  32'(mn_enq_ready),  1);
  endtask

  // Idle the inputs, let the scoreboard catch up, then pulse reset between edges.
  task automatic pulse_reset();
    step(0, 0, 0, 0, 0);
    drain();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_clear();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int keys_a[4] = '{5, 9, 2, 7};
    int keys_b[3] = '{16'h30, 16'h10, 16'h20};
    rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq = 1'b0; enq_key = '0; enq_data = '0;
    model_clear();
    #1;
    check_reset_vals("reset");
    #2;
    rst_n = 1'b1;

    // Dequeue on empty is ignored.
    step(0, 0, 0, 0, 1);
    // Key zero is a legal entry.
    step(0, 1, 0, 16'hAAAA, 0);
    step(0, 0, 0, 0, 1);

    // Ordering: max sees 9,7,5,2; min sees 2,5,7,9.
    foreach (keys_a[i]) step(0, 1, keys_a[i], keys_a[i] * 16'h0101, 0);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Fill to full, then try a plain enqueue and a replace.
    for (int k = 1; k <= N; k++) step(0, 1, k, k * 16'h0111, 0);
    step(0, 0, 0, 0, 0);
    #1;
    chk("max enq_ready full", 32'(mx_enq_ready), 0);
    chk("min enq_ready full", 32'(mn_enq_ready), 0);
    step(0, 1, 10, 16'hBEEF, 0);
    step(0, 1, 4, 16'h4444, 1);
    #1;
    chk("max enq_ready replace", 32'(mx_enq_ready), 1);
    chk("min enq_ready replace", 32'(mn_enq_ready), 1);
    repeat (3) step(0, 0, 0, 0, 1);

    // Flush wins over a simultaneous enqueue.
    step(1, 1, 16'h55, 16'h5555, 0);
    foreach (keys_b[i]) step(0, 1, keys_b[i], keys_b[i] + 16'h1000, 0);
    step(1, 1, 16'h55, 16'h5555, 0);

    // Asynchronous reset mid-stream with three entries held.
    foreach (keys_b[i]) step(0, 1, keys_b[i] + 1, keys_b[i] + 16'h2000, 0);
    pulse_reset();

    // Queue works again after reset.
    step(0, 1, 16'h0042, 16'h1234, 0);
    step(0, 0, 0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_array_kv.md
Name: register_array_kv

Overview:
- Parametrised successor to the register-array priority queue.
- Each entry holds a key plus a payload and carries an explicit per-slot valid bit, so a key of zero is a legal value.
- Ordering is selectable at elaboration time: max-first or min-first.
- Enqueue and dequeue both use handshakes, with replace, flush and occupancy reporting.
- Sits between schedulers and consumers that need the best-priority item visible at the head every cycle.

Parameters:
- QUEUE_SIZE, 8, number of slots; must be even and >=4 (elaboration $error otherwise).
- KEY_WIDTH, 16, priority key width.
- DATA_WIDTH, 16, payload width.
- MIN_FIRST, 0, 0 = largest key at the head; 1 = smallest key at the head.

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous clear of all slots
- i_enq_valid  in  1  enqueue request
- o_enq_ready  out  1  enqueue can be accepted
- i_enq_key  in  KEY_WIDTH  key to insert
- i_enq_data  in  DATA_WIDTH  payload to insert
- i_deq  in  1  pop the head
- o_head_valid  out  1  head slot holds a valid entry
- o_head_key  out  KEY_WIDTH  head key
- o_head_data  out  DATA_WIDTH  head payload
- o_count  out  $clog2(QUEUE_SIZE)+1  number of valid entries
- o_full  out  1  count == QUEUE_SIZE
- o_empty  out  1  count == 0

Behaviour:
- One clock; reset is asynchronous and active-low: i_CLK, i_RSTn.
- Reset: all slot valid bits, keys and payloads are 0, and count is 0.
  - Output values in reset: o_head_valid=0, o_head_key=0, o_head_data=0, o_count=0, o_full=0, o_empty=1, o_enq_ready=1.
  - Asserting reset mid-operation discards all contents immediately.
- Priority order:
  - A valid slot beats an invalid slot.
  - Between two valid slots, the larger key wins (the smaller key if MIN_FIRST=1).
  - On equal keys there is no swap; the lower index keeps its position.
- o_enq_ready = !full || i_deq. Replace on a full queue is always accepted.
- Accepted operations: enq_acc = i_enq_valid && o_enq_ready; deq_acc = i_deq && !empty. Op decode, highest priority first:
  - FLUSH (i_flush): all valid bits, keys and payloads cleared next cycle; count=0; enq/deq ignored.
  - REPLACE (enq_acc && deq_acc): slot0 <= {1, key, data}; count unchanged.
  - ENQ (enq_acc only): find k = lowest index whose valid bit is 0; slots 1..k <= slots 0..k-1; slot0 <= new entry; count+1.
  - DEQ (deq_acc only): slot0 valid <= 0, key/data <= 0; count-1.
  - NOP: i_deq on an empty queue is ignored, no underflow.
  - Enqueue while full without i_deq is not accepted; state is unchanged.
- Each cycle the post-op array (stage1) passes through two compare-exchange layers before the register:
  - Layer A: pairs (0,1),(2,3),…
  - Layer B: pairs (1,2),(3,4),…,(N-3,N-2).
  - Slot 0 takes the layer-A winner of pair (0,1); slot N-1 takes the layer-A loser of pair (N-2,N-1).
- Invariant: after every clock edge, slot0 holds the highest-priority valid entry present. Verification checks this with a reference model every cycle.
- Latency: o_head_* are registered slot0 and reflect an op one cycle after it is accepted. Throughput is one op per cycle.
- Payload always travels with its key through every swap and shift.
- o_count is registered; o_full and o_empty decode from it.

Decomposition:
- Package register_array_pkg holds:
  - enum op_e {OP_NOP, OP_ENQ, OP_DEQ, OP_REPLACE, OP_FLUSH};
  - function is_legal_size(int) for the parameter check.
- The entry struct {valid, key, data} is declared locally, because its width is parameter-dependent.
- Sub-module register_array_cas: compare-and-swap cell, parametrised by KEY_WIDTH, DATA_WIDTH and MIN_FIRST.
  - Takes two entries; returns hi/lo entries in priority order.
  - Instantiated N/2 times for layer A and N/2-1 times for layer B.

Test Plan:
- Reset/empty: after reset, pulse i_deq -> o_empty=1, o_count=0, o_head_valid=0, no state change.
- Zero-key legality: enqueue key 0 data 0xAAAA into an empty queue -> next cycle o_head_valid=1, key 0, data 0xAAAA, count 1.
- Max ordering (MIN_FIRST=0, N=8): enqueue keys 5,9,2,7 on consecutive cycles, then dequeue 4 times -> head keys seen are 9,7,5,2, each payload matching its key, then o_empty=1.
- Min ordering (MIN_FIRST=1): same stimulus -> head keys 2,5,7,9.
- Full/replace: fill 8 entries with keys 1..8 -> o_full=1, o_enq_ready=0.
  - Assert i_enq_valid alone -> ignored, count 8.
  - Assert i_enq_valid+i_deq with key 4 -> head 8 removed, new head 7, count 8.
- Flush and async reset mid-stream: with count=3, assert i_flush together with i_enq_valid -> count 0 next cycle, enqueue dropped.
  - Repeat with i_RSTn pulsed low between edges -> outputs return to reset values immediately.
